// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one add/subtract datapath between NREQ requesters.
// Optional response counters (op_count, cb_count) are built when ADDSUB_ARB_CNT_EN is defined.
module addsub_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_cb,
    output logic                  rsp_op
`ifdef ADDSUB_ARB_CNT_EN
    ,
    output logic [7:0]            op_count,
    output logic [7:0]            cb_count
`endif
);

    // state | meaning
    // IDLE  | offer one round-robin grant, latch operands on handshake
    // EXEC  | datapath works on latched operands, result registered
    // RESP  | result held on rsp_* until the consumer accepts it
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    id_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              op_q;
    logic [WIDTH:0]    dp_out;
    logic              gnt_found;
    logic [IDW-1:0]    gnt_idx;
    int                pos;

    // Extra top bit is the carry for add and the unsigned borrow for subtract.
    always_comb begin
        if (op_q)
            dp_out = {1'b0, a_q} - {1'b0, b_q};
        else
            dp_out = {1'b0, a_q} + {1'b0, b_q};
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        pos       = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NREQ)
                pos = pos - NREQ;
            if (!gnt_found && req_valid[pos]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(pos);
            end
        end
    end

    // Gated by rst_n so the grant drops as soon as reset asserts.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_found && rst_n)
            req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_cb     <= 1'b0;
            rsp_op     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        a_q   <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                        b_q   <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                        op_q  <= req_op[gnt_idx];
                        id_q  <= gnt_idx;
                        if (gnt_idx == IDW'(NREQ-1))
                            rr_ptr <= '0;
                        else
                            rr_ptr <= gnt_idx + IDW'(1);
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= dp_out[WIDTH-1:0];
                    rsp_cb     <= dp_out[WIDTH];
                    rsp_op     <= op_q;
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDSUB_ARB_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
            cb_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            op_count <= op_count + 8'd1;
            if (rsp_cb)
                cb_count <= cb_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Self-checking bench for addsub_rr_arbiter: directed test-plan cases plus randomized
// traffic against a transaction-level reference model.
module tb_addsub_rr_arbiter;
    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       req_op = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_cb;
    logic                  rsp_op;
`ifdef ADDSUB_ARB_CNT_EN
    logic [7:0]            op_count;
    logic [7:0]            cb_count;
`endif

    addsub_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
`ifdef ADDSUB_ARB_CNT_EN
        .op_count  (op_count),
        .cb_count  (cb_count),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result),
        .rsp_cb    (rsp_cb),
        .rsp_op    (rsp_op)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester-side stimulus
    logic             tb_valid [NREQ];
    logic [WIDTH-1:0] tb_a     [NREQ];
    logic [WIDTH-1:0] tb_b     [NREQ];
    logic             tb_op    [NREQ];
    logic             tb_rsp_ready = 1'b0;
    bit               hold_mode = 1'b0;

    // Reference model: phase 0 waiting for grant, 1 computing, 2 result offered
    int m_ptr = 0;
    int m_phase = 0;
    int e_id = 0, e_res = 0, e_cb = 0, e_op = 0;
    int p_id = 0, p_res = 0, p_cb = 0, p_op = 0;
    int m_ops = 0, m_cbs = 0;
    int obs_q[$];

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]              = tb_valid[i];
            req_a[i*WIDTH +: WIDTH]   = tb_a[i];
            req_b[i*WIDTH +: WIDTH]   = tb_b[i];
            req_op[i]                 = tb_op[i];
        end
        rsp_ready = tb_rsp_ready;
    endtask

    task automatic run_cycle();
        logic [NREQ-1:0] exp_rdy;
        int g;
        int a, b;
        @(posedge clk);
        #1;
        drive();
        #3;
        exp_rdy = '0;
        g = -1;
        if (m_phase == 0) begin
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && tb_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) obs_q.push_back(i);
`ifdef ADDSUB_ARB_CNT_EN
        check("op_count", 32'(op_count), m_ops);
        check("cb_count", 32'(cb_count), m_cbs);
`endif
        if (m_phase == 2) begin
            check("rsp_valid", 32'(rsp_valid), 1);
        end else begin
            check("rsp_valid", 32'(rsp_valid), 0);
        end
        check("rsp_id", 32'(rsp_id), e_id);
        check("rsp_result", 32'(rsp_result), e_res);
        check("rsp_cb", 32'(rsp_cb), e_cb);
        check("rsp_op", 32'(rsp_op), e_op);
        case (m_phase)
            0: if (g >= 0) begin
                a = int'(tb_a[g]);
                b = int'(tb_b[g]);
                p_id = g;
                p_op = int'(tb_op[g]);
                if (tb_op[g]) begin
                    p_res = (a - b) & MASK;
                    p_cb  = (a < b) ? 1 : 0;
                end else begin
                    p_res = (a + b) & MASK;
                    p_cb  = ((a + b) > MASK) ? 1 : 0;
                end
                m_ptr = (g + 1) % NREQ;
                m_phase = 1;
                if (!hold_mode) tb_valid[g] = 1'b0;
            end
            1: begin
                e_id = p_id; e_res = p_res; e_cb = p_cb; e_op = p_op;
                m_phase = 2;
            end
            default: if (tb_rsp_ready) begin
                m_ops = (m_ops + 1) % 256;
                if (e_cb != 0) m_cbs = (m_cbs + 1) % 256;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_result", 32'(rsp_result), 0);
        check("rst_rsp_cb", 32'(rsp_cb), 0);
        check("rst_rsp_op", 32'(rsp_op), 0);
`ifdef ADDSUB_ARB_CNT_EN
        check("rst_op_count", 32'(op_count), 0);
        check("rst_cb_count", 32'(cb_count), 0);
`endif
        m_ptr = 0; m_phase = 0;
        e_id = 0; e_res = 0; e_cb = 0; e_op = 0;
        m_ops = 0; m_cbs = 0;
        for (int i = 0; i < NREQ; i++) tb_valid[i] = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic single_op(input int id, input int a, input int b, input int op,
                             input int x_res, input int x_cb);
        tb_valid[id] = 1'b1;
        tb_a[id] = WIDTH'(a);
        tb_b[id] = WIDTH'(b);
        tb_op[id] = 1'(op);
        tb_rsp_ready = 1'b1;
        repeat (4) run_cycle();
        check("tp_result", 32'(rsp_result), x_res);
        check("tp_cb", 32'(rsp_cb), x_cb);
        check("tp_id", 32'(rsp_id), id);
    endtask

    initial begin
        int exp_order[5];
        int guard;
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) begin
            tb_valid[i] = 1'b0; tb_a[i] = '0; tb_b[i] = '0; tb_op[i] = 1'b0;
        end
        #2;
        apply_reset();

        // Test-plan arithmetic cases
        single_op(0, 4'b1010, 4'b0101, 0, 4'b1111, 0);
        single_op(1, 4'b0100, 4'b0111, 1, 4'b1101, 1);
        single_op(1, 4'b1010, 4'b0101, 1, 4'b0101, 0);
        single_op(2, 4'b1001, 4'b1111, 0, 4'b1000, 1);
`ifdef ADDSUB_ARB_CNT_EN
        check("tp_op_count", 32'(op_count), 4);
        check("tp_cb_count", 32'(cb_count), 2);
`endif

        // All requesters held valid: grant order from a freshly reset pointer
        apply_reset();
        hold_mode = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            tb_valid[i] = 1'b1; tb_a[i] = WIDTH'(i + 3); tb_b[i] = WIDTH'(2 * i + 1); tb_op[i] = 1'(i);
        end
        tb_rsp_ready = 1'b1;
        obs_q.delete();
        guard = 0;
        while (obs_q.size() < 5 && guard < 40) begin
            run_cycle();
            guard++;
        end
        check("order_count", obs_q.size(), 5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++)
            check("grant_order", obs_q[i], exp_order[i]);
        hold_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) tb_valid[i] = 1'b0;
        repeat (4) run_cycle();

        // Backpressure with a competing request pending
        tb_valid[0] = 1'b1; tb_a[0] = 4'd7; tb_b[0] = 4'd12; tb_op[0] = 1'b1;
        tb_valid[3] = 1'b1; tb_a[3] = 4'd6; tb_b[3] = 4'd6; tb_op[3] = 1'b0;
        tb_rsp_ready = 1'b0;
        repeat (7) run_cycle();
        check("bp_phase", m_phase, 2);
        tb_rsp_ready = 1'b1;
        repeat (5) run_cycle();

        // Reset asserted while an operation is in EXEC
        tb_valid[1] = 1'b1; tb_a[1] = 4'd9; tb_b[1] = 4'd9;
        guard = 0;
        while (m_phase != 1 && guard < 10) begin
            run_cycle();
            guard++;
        end
        check("reach_exec", m_phase, 1);
        tb_valid[2] = 1'b1;
        drive();
        @(posedge clk);
        #2;
        apply_reset();
        tb_valid[0] = 1'b1; tb_a[0] = 4'd15; tb_b[0] = 4'd1; tb_op[0] = 1'b0;
        tb_valid[3] = 1'b1; tb_a[3] = 4'd2;  tb_b[3] = 4'd3; tb_op[3] = 1'b1;
        obs_q.delete();
        run_cycle();
        check("post_rst_grant", (obs_q.size() > 0) ? obs_q[0] : -1, 0);
        repeat (8) run_cycle();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!tb_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        tb_valid[i] = 1'b1;
                        tb_a[i] = WIDTH'($urandom);
                        tb_b[i] = WIDTH'($urandom);
                        tb_op[i] = 1'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    tb_valid[i] = 1'b0;
                end
            end
            tb_rsp_ready = ($urandom_range(0, 3) != 0);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
